// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter and related arbiters.
// Optional feature macro: WRITEBACK_ARBITER_PERF_EN (per-pipe stall counters).
package writeback_arbiter_pkg;

   localparam int WB_DATA_BITS    = 32;
   localparam int WB_ADDR_BITS    = 5;
   // Default width of the instruction sequence number.
   // The arbiter's p_seq_num_bits defaults to this value and must match it.
   localparam int WB_SEQ_NUM_BITS = 5;
   localparam int WB_CNT_BITS     = 16;

   // One writeback request: the fields that travel with a completion.
   typedef struct packed {
      logic [WB_SEQ_NUM_BITS-1:0] seq_num;
      logic [WB_ADDR_BITS-1:0]    waddr;
      logic [WB_DATA_BITS-1:0]    wdata;
      logic                       wen;
   } wb_req_t;

   // Width of a round-robin pointer over n requesters (never less than 1).
   function automatic int rr_ptr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/writeback_arbiter_rr_priority_picker.sv
// Round-robin priority picker: the first set request at or after ptr wins,
// scanning upward and wrapping. Purely combinational so issue arbiters can reuse it.
module rr_priority_picker
   import writeback_arbiter_pkg::*;
#(
   parameter  int p_n        = 2,
   localparam int p_ptr_bits = rr_ptr_bits(p_n)
) (
   input  logic [p_n-1:0]        req,
   input  logic [p_ptr_bits-1:0] ptr,
   output logic [p_n-1:0]        gnt,
   output logic [p_ptr_bits-1:0] idx,
   output logic                  any
);

   // Walk offsets from farthest to nearest so the nearest request overrides.
   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = p_n - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % p_n;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = p_ptr_bits'(j);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: shares one completion bus among p_num_pipes execute pipes.
// A round-robin winner is picked combinationally and registered onto cmp_*.
// Optional feature macro: WRITEBACK_ARBITER_PERF_EN adds stall_cnt counters.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter  int p_num_pipes    = 2,
   parameter  int p_seq_num_bits = WB_SEQ_NUM_BITS,
   localparam int p_ptr_bits     = rr_ptr_bits(p_num_pipes)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_num_pipes-1:0]                req_val,
   output logic [p_num_pipes-1:0]                req_rdy,
   input  logic [p_num_pipes*p_seq_num_bits-1:0] req_seq_num,
   input  logic [p_num_pipes*WB_ADDR_BITS-1:0]   req_waddr,
   input  logic [p_num_pipes*WB_DATA_BITS-1:0]   req_wdata,
   input  logic [p_num_pipes-1:0]                req_wen,
   output logic                                  cmp_val,
   output logic [p_seq_num_bits-1:0]             cmp_seq_num,
   output logic [WB_ADDR_BITS-1:0]               cmp_waddr,
   output logic [WB_DATA_BITS-1:0]               cmp_wdata,
   output logic                                  cmp_wen
`ifdef WRITEBACK_ARBITER_PERF_EN
   ,
   output logic [p_num_pipes*WB_CNT_BITS-1:0]    stall_cnt
`endif
);

   logic [p_num_pipes-1:0] grant_oh;
   logic [p_ptr_bits-1:0]  win_idx;
   logic                   any_grant;
   wb_req_t                win_req;

   logic                   cmp_val_q, cmp_val_d;
   wb_req_t                cmp_q, cmp_d;
   logic [p_ptr_bits-1:0]  ptr_q, ptr_d;

   rr_priority_picker #(
      .p_n (p_num_pipes)
   ) u_picker (
      .req (req_val),
      .ptr (ptr_q),
      .gnt (grant_oh),
      .idx (win_idx),
      .any (any_grant)
   );

   assign req_rdy = grant_oh;

   // Select only the winner's fields; other pipes' fields never reach the register.
   always_comb begin
      win_req         = '0;
      win_req.seq_num = req_seq_num[int'(win_idx)*p_seq_num_bits +: p_seq_num_bits];
      win_req.waddr   = req_waddr[int'(win_idx)*WB_ADDR_BITS +: WB_ADDR_BITS];
      win_req.wdata   = req_wdata[int'(win_idx)*WB_DATA_BITS +: WB_DATA_BITS];
      win_req.wen     = req_wen[win_idx];
   end

   // Next completion and pointer: load winner on grant, else drop valid/wen and hold data.
   always_comb begin
      cmp_val_d = any_grant;
      cmp_d     = cmp_q;
      ptr_d     = ptr_q;
      if (any_grant) begin
         cmp_d = win_req;
         ptr_d = (win_idx == p_ptr_bits'(p_num_pipes - 1)) ? '0 : win_idx + 1'b1;
      end else begin
         cmp_d.wen = 1'b0;
      end
   end

   // Completion register and round-robin pointer; reset drops any pending completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmp_val_q <= 1'b0;
         cmp_q     <= '0;
         ptr_q     <= '0;
      end else begin
         cmp_val_q <= cmp_val_d;
         cmp_q     <= cmp_d;
         ptr_q     <= ptr_d;
      end
   end

   assign cmp_val     = cmp_val_q;
   assign cmp_seq_num = cmp_q.seq_num;
   assign cmp_waddr   = cmp_q.waddr;
   assign cmp_wdata   = cmp_q.wdata;
   assign cmp_wen     = cmp_q.wen;

`ifdef WRITEBACK_ARBITER_PERF_EN
   logic [p_num_pipes-1:0][WB_CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

   // Count cycles each pipe wanted the bus but lost; saturate instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < p_num_pipes; i++) begin
         if (req_val[i] && !grant_oh[i] && (stall_cnt_q[i] != '1)) begin
            stall_cnt_d[i] = stall_cnt_q[i] + WB_CNT_BITS'(1);
         end
      end
   end

   // Stall counter storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a two-pipe instance driven through a
// scoreboard with an independent round-robin model, plus a three-pipe instance
// exercising pointer wrap. Stall counters are checked when WRITEBACK_ARBITER_PERF_EN is set.
module tb_writeback_arbiter;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // Two-pipe instance
   logic [1:0]  a_val, a_rdy, a_wen;
   logic [9:0]  a_seq, a_waddr;
   logic [63:0] a_wdata;
   logic        a_cval, a_cwen;
   logic [4:0]  a_cseq, a_cwaddr;
   logic [31:0] a_cwdata;
`ifdef WRITEBACK_ARBITER_PERF_EN
   logic [31:0] a_stall;
`endif

   // Three-pipe instance
   logic [2:0]  b_val, b_rdy, b_wen;
   logic [14:0] b_seq, b_waddr;
   logic [95:0] b_wdata;
   logic        b_cval, b_cwen;
   logic [4:0]  b_cseq, b_cwaddr;
   logic [31:0] b_cwdata;
`ifdef WRITEBACK_ARBITER_PERF_EN
   logic [47:0] b_stall;
`endif

   writeback_arbiter #(.p_num_pipes(2)) u_a (
      .clk         (clk),
      .rst         (rst),
      .req_val     (a_val),
      .req_rdy     (a_rdy),
      .req_seq_num (a_seq),
      .req_waddr   (a_waddr),
      .req_wdata   (a_wdata),
      .req_wen     (a_wen),
      .cmp_val     (a_cval),
      .cmp_seq_num (a_cseq),
      .cmp_waddr   (a_cwaddr),
      .cmp_wdata   (a_cwdata),
      .cmp_wen     (a_cwen)
`ifdef WRITEBACK_ARBITER_PERF_EN
      ,
      .stall_cnt   (a_stall)
`endif
   );

   writeback_arbiter #(.p_num_pipes(3)) u_b (
      .clk         (clk),
      .rst         (rst),
      .req_val     (b_val),
      .req_rdy     (b_rdy),
      .req_seq_num (b_seq),
      .req_waddr   (b_waddr),
      .req_wdata   (b_wdata),
      .req_wen     (b_wen),
      .cmp_val     (b_cval),
      .cmp_seq_num (b_cseq),
      .cmp_waddr   (b_cwaddr),
      .cmp_wdata   (b_cwdata),
      .cmp_wen     (b_cwen)
`ifdef WRITEBACK_ARBITER_PERF_EN
      ,
      .stall_cnt   (b_stall)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic        val;
      logic [4:0]  seq;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        wen;
   } exp_t;

   exp_t sb_q[$];
   exp_t last;
   int   mptr;

   task automatic model_clear();
      sb_q.delete();
      mptr       = 0;
      last.val   = 1'b0;
      last.seq   = '0;
      last.waddr = '0;
      last.wdata = '0;
      last.wen   = 1'b0;
   endtask

   // Compare the completion bus against the oldest scoreboard entry.
   task automatic pop_check();
      exp_t e;
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      chk("cmp_val",   a_cval,   e.val);
      chk("cmp_wen",   a_cwen,   e.wen);
      chk("cmp_seq",   a_cseq,   e.seq);
      chk("cmp_waddr", a_cwaddr, e.waddr);
      chk("cmp_wdata", a_cwdata, e.wdata);
   endtask

   // One cycle on the two-pipe instance: check previous completion, drive, check grant, predict.
   task automatic step_a(input logic [1:0] val, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] w0, input logic [4:0] w1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] wen);
      exp_t e;
      int   win;
      @(posedge clk); #1;
      pop_check();
      a_val = val; a_seq = {s1, s0}; a_waddr = {w1, w0}; a_wdata = {d1, d0}; a_wen = wen;
      win = -1;
      for (int k = 0; k < N; k++) begin
         if (win < 0 && val[(mptr + k) % N]) win = (mptr + k) % N;
      end
      #3;
      chk("req_rdy", a_rdy, (win < 0) ? 64'd0 : (64'd1 << win));
      if (win < 0) begin
         e     = last;
         e.val = 1'b0;
         e.wen = 1'b0;
      end else begin
         e.val   = 1'b1;
         e.seq   = (win == 1) ? s1 : s0;
         e.waddr = (win == 1) ? w1 : w0;
         e.wdata = (win == 1) ? d1 : d0;
         e.wen   = wen[win];
         last    = e;
         mptr    = (win + 1) % N;
      end
      sb_q.push_back(e);
   endtask

   task automatic flush_a();
      @(posedge clk); #1;
      pop_check();
      a_val = '0;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      a_val = '0; a_seq = '0; a_waddr = '0; a_wdata = '0; a_wen = '0;
      b_val = '0; b_waddr = '0; b_wdata = '0; b_wen = '0;
      b_seq = {5'd22, 5'd21, 5'd20};
      #2;
      chk("rst_cmp_val",   a_cval,   1'b0);
      chk("rst_cmp_wen",   a_cwen,   1'b0);
      chk("rst_cmp_seq",   a_cseq,   5'd0);
      chk("rst_cmp_waddr", a_cwaddr, 5'd0);
      chk("rst_cmp_wdata", a_cwdata, 32'd0);
      chk("rst_b_cmp_val", b_cval,   1'b0);
      model_clear();
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      model_clear();
      do_reset();

      // Single request on pipe 0, then idle: completion appears once then drops.
      step_a(2'b01, 5'd3, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b01);
      step_a(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
      step_a(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
      flush_a();

      // Both pipes valid for four cycles: grants alternate 0,1,0,1.
      do_reset();
      for (int c = 0; c < 4; c++)
         step_a(2'b11, 5'd1, 5'd2, 5'd10, 5'd11, 32'hA0A0_0001, 32'hB0B0_0002, 2'b11);
      flush_a();

      // Write-disabled completion still reports its sequence number.
      step_a(2'b10, 5'd0, 5'd9, 5'd0, 5'd7, 32'h0, 32'h1234_5678, 2'b00);
      step_a(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00);
      flush_a();

      // Random traffic.
      for (int c = 0; c < 40; c++)
         step_a(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, $urandom, 2'($urandom_range(0, 3)));
      flush_a();

      // Reset mid-operation: completion drops asynchronously, arbitration restarts at pipe 0.
      do_reset();
      step_a(2'b11, 5'd4, 5'd6, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, 2'b11);
      @(posedge clk); #1;
      pop_check();
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_cmp_val", a_cval, 1'b0);
      a_val = '0;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b1;
      step_a(2'b11, 5'd4, 5'd6, 5'd1, 5'd2, 32'h3333_3333, 32'h4444_4444, 2'b11);
      flush_a();

      // Three pipes: grant pipe1, then pipe2 with ptr=2, then all valid -> wrap to 0, then 1.
      do_reset();
      b_val = 3'b010;
      #3; chk("b_rdy_p1", b_rdy, 3'b010);
      @(posedge clk); #1;
      chk("b_seq_p1", b_cseq, 5'd21);
      b_val = 3'b100;
      #3; chk("b_rdy_p2", b_rdy, 3'b100);
      @(posedge clk); #1;
      chk("b_seq_p2", b_cseq, 5'd22);
      b_val = 3'b111;
      #3; chk("b_rdy_wrap", b_rdy, 3'b001);
      @(posedge clk); #1;
      chk("b_seq_wrap", b_cseq, 5'd20);
      chk("b_val_wrap", b_cval, 1'b1);
      #3; chk("b_rdy_next", b_rdy, 3'b010);
      @(posedge clk); #1;
      chk("b_seq_next", b_cseq, 5'd21);
      b_val = '0;
`ifdef WRITEBACK_ARBITER_PERF_EN
      chk("b_stall", b_stall, {16'd2, 16'd1, 16'd1});

      // Both pipes valid six cycles: each loses three times.
      do_reset();
      for (int c = 0; c < 6; c++)
         step_a(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 32'h5, 32'h6, 2'b11);
      flush_a();
      chk("stall0_6cyc", a_stall[15:0],  16'd3);
      chk("stall1_6cyc", a_stall[31:16], 16'd3);

      // Starve pipe 1 long enough to saturate its counter.
      a_val = 2'b11;
      force u_a.grant_oh = 2'b01;
      repeat (70000) @(posedge clk);
      #1;
      release u_a.grant_oh;
      a_val = '0;
      chk("stall1_sat", a_stall[31:16], 16'hFFFF);
      chk("stall0_hold", a_stall[15:0], 16'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
